// File: rtl/mcse_hs_pkg.sv
// Shared types and GPIO bit map for the host handshake controller.
package mcse_hs_pkg;

  typedef enum logic [1:0] {
    CmdHostReset = 2'd0,
    CmdBusWakeup = 2'd1,
    CmdOpRelease = 2'd2,
    CmdReserved  = 2'd3
  } hs_cmd_e;

  typedef enum logic [2:0] {
    StIdle,
    StWaitRtz,
    StReq,
    StRelease,
    StDone,
    StErr
  } hs_state_e;

  localparam int unsigned ReqResetBit = 0;
  localparam int unsigned ReqWakeBit  = 6;
  localparam int unsigned ReqRelBit   = 4;
  localparam int unsigned AckResetBit = 1;
  localparam int unsigned AckWakeBit  = 7;
  localparam int unsigned AckRelBit   = 5;

  // acks packed as {release, wakeup, reset}; the reserved type never has an ack.
  function automatic logic ack_of(hs_cmd_e cmd, logic [2:0] acks);
    logic ack;
    ack = 1'b0;
    case (cmd)
      CmdHostReset: ack = acks[0];
      CmdBusWakeup: ack = acks[1];
      CmdOpRelease: ack = acks[2];
      default:      ack = 1'b0;
    endcase
    return ack;
  endfunction

endpackage

// File: rtl/hs_timeout_cnt.sv
// Saturating wait counter for the host acknowledge timeout; expired at TIMEOUT_CYCLES-1.
module hs_timeout_cnt
  import mcse_hs_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] Limit = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == Limit);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en && !expired) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/host_handshake_ctrl.sv
// Drives host reset / bus wakeup / operation release request-ack handshakes over GPIO.
// Define HOST_HS_TIMEOUT_EN to abort waits for an acknowledge after TIMEOUT_CYCLES.
module host_handshake_ctrl
  import mcse_hs_pkg::*;
#(
  parameter int unsigned GPIO_N         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd_type,
  output logic              cmd_ready,
  input  logic [GPIO_N-1:0] gpio_in,
  output logic [GPIO_N-1:0] gpio_out,
  output logic              done,
  output logic              err_timeout,
  output logic              busy
);

  hs_state_e state_q, state_d;
  hs_cmd_e   type_q, type_d;
  hs_cmd_e   cmd_in;
  logic      req_rst_q, req_rst_d;
  logic      req_wake_q, req_wake_d;
  logic      req_rel_q, req_rel_d;
  logic [2:0] acks;
  logic      ack_cur, ack_new, accept, timed_out;
  logic      unused_gpio_in;

  assign cmd_in  = hs_cmd_e'(cmd_type);
  assign accept  = cmd_valid && (state_q == StIdle);
  assign acks    = {gpio_in[AckRelBit], gpio_in[AckWakeBit], gpio_in[AckResetBit]};
  assign ack_cur = ack_of(type_q, acks);
  assign ack_new = ack_of(cmd_in, acks);
  assign unused_gpio_in = ^gpio_in;

`ifdef HOST_HS_TIMEOUT_EN
  logic cnt_clear, cnt_en;

  assign cnt_en    = (state_q == StWaitRtz) || (state_q == StReq);
  assign cnt_clear = ((state_d == StWaitRtz) || (state_d == StReq)) && (state_d != state_q);

  hs_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk    (clk),
    .rst    (rst),
    .clear  (cnt_clear),
    .en     (cnt_en),
    .expired(timed_out)
  );
`else
  assign timed_out = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          type_d = cmd_in;
          case (cmd_in)
            CmdReserved:  state_d = StErr;
            CmdOpRelease: state_d = StReq;
            // A stale ack must return to zero before a new request goes out.
            default:      state_d = ack_new ? StWaitRtz : StReq;
          endcase
        end
      end
      StWaitRtz: begin
        if (!ack_cur) begin
          state_d = StReq;
        end else if (timed_out) begin
          state_d = StErr;
        end
      end
      StReq: begin
        // Ack has priority over a simultaneous timeout.
        if (ack_cur) begin
          state_d = StRelease;
        end else if (timed_out) begin
          state_d = StErr;
        end
      end
      StRelease: state_d = StDone;
      StDone:    state_d = StIdle;
      StErr:     state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Reset/wakeup requests exist only while in REQ; release is sticky until a host reset.
  always_comb begin
    req_rst_d  = (state_d == StReq) && (type_d == CmdHostReset);
    req_wake_d = (state_d == StReq) && (type_d == CmdBusWakeup);
    req_rel_d  = req_rel_q;
    if (accept && (cmd_in == CmdHostReset)) begin
      req_rel_d = 1'b0;
    end
    if ((state_d == StReq) && (type_d == CmdOpRelease)) begin
      req_rel_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      type_q     <= CmdHostReset;
      req_rst_q  <= 1'b0;
      req_wake_q <= 1'b0;
      req_rel_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      type_q     <= type_d;
      req_rst_q  <= req_rst_d;
      req_wake_q <= req_wake_d;
      req_rel_q  <= req_rel_d;
    end
  end

  always_comb begin
    gpio_out              = '0;
    gpio_out[ReqResetBit] = req_rst_q;
    gpio_out[ReqWakeBit]  = req_wake_q;
    gpio_out[ReqRelBit]   = req_rel_q;
  end

  assign cmd_ready   = (state_q == StIdle);
  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StDone);
  assign err_timeout = (state_q == StErr);

endmodule

// File: tb/tb_host_handshake_ctrl.sv
// Randomised scoreboard bench for host_handshake_ctrl; timeout scenarios run when
// HOST_HS_TIMEOUT_EN is defined.
module tb_host_handshake_ctrl;

  localparam int unsigned GpioN    = 32;
  localparam int unsigned ToCycles = 16;
  localparam int RqRst = 0, RqWake = 6, RqRel = 4;
  localparam int AkRst = 1, AkWake = 7, AkRel = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic [1:0]       cmd_type;
  logic             cmd_ready;
  logic [GpioN-1:0] gpio_in;
  logic [GpioN-1:0] gpio_out;
  logic             done;
  logic             err_timeout;
  logic             busy;

  always #5 clk = ~clk;

  host_handshake_ctrl #(
    .GPIO_N        (GpioN),
    .TIMEOUT_CYCLES(ToCycles)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_type   (cmd_type),
    .cmd_ready  (cmd_ready),
    .gpio_in    (gpio_in),
    .gpio_out   (gpio_out),
    .done       (done),
    .err_timeout(err_timeout),
    .busy       (busy)
  );

  typedef struct {
    bit is_err;
    bit rel;
    bit need_ack;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   rel_m = 1'b0;
  bit   ack_given = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Every done/err pulse must match the oldest outstanding command.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && (done || err_timeout)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: done=%0b err=%0b with nothing pending", done,
                 err_timeout);
      end else begin
        e = exp_q.pop_front();
        chk("pulse_err", 32'(err_timeout), 32'(e.is_err));
        chk("pulse_done", 32'(done), 32'(!e.is_err));
        chk("gpio_at_pulse", gpio_out, e.rel ? 32'h10 : 32'h0);
        if (e.need_ack) chk("ack_before_done", 32'(ack_given), 32'd1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] t, input bit push, input bit exp_err);
    int n;
    n = 0;
    while (!cmd_ready && n < 200) begin
      tick();
      n++;
    end
    chk("ready_wait", 32'(cmd_ready), 32'd1);
    if (t == 2'd0) rel_m = 1'b0;
    else if (t == 2'd2 && !exp_err) rel_m = 1'b1;
    ack_given = 1'b0;
    if (push) exp_q.push_back(exp_t'{is_err: exp_err, rel: rel_m, need_ack: !exp_err});
    cmd_valid = 1'b1;
    cmd_type  = t;
    tick();
    cmd_valid = 1'b0;
    cmd_type  = 2'($urandom);
  endtask

  // Host side: wait for the request, ack after d cycles (optionally a foreign ack and
  // ignored commands meanwhile), hold the ack h cycles.
  task automatic host_ack(input int rq, input int ak, input int wrong, input int d,
                          input int h);
    int n;
    n = 0;
    while (!gpio_out[rq] && n < 100) begin
      tick();
      n++;
    end
    chk("req_rise", 32'(gpio_out[rq]), 32'd1);
    for (int i = 0; i < d; i++) begin
      if (wrong >= 0) gpio_in[wrong] = 1'b1;
      cmd_valid = 1'b1;
      cmd_type  = 2'($urandom);
      tick();
      chk("req_held", 32'(gpio_out[rq]), 32'd1);
    end
    cmd_valid = 1'b0;
    if (wrong >= 0) gpio_in[wrong] = 1'b0;
    gpio_in[ak] = 1'b1;
    ack_given   = 1'b1;
    tick();
    chk("req_after_ack", 32'(gpio_out[rq]), 32'(rq == RqRel));
    for (int i = 1; i < h; i++) tick();
    gpio_in[ak] = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 100) begin
      tick();
      n++;
    end
    chk("idle_reached", 32'({busy, exp_q.size() == 0}), 32'd1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin : stim
    logic [GpioN-1:0] g;
    int t, d, h, wrong, rq, ak;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_type  = 2'd0;
    gpio_in   = '0;
    repeat (5) tick();
    rst = 1'b0;
    chk("reset_gpio", gpio_out, 32'h0);
    chk("reset_ready", 32'(cmd_ready), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_err", 32'(err_timeout), 32'd0);

    // Host reset with late ack, then a second one stalled by a lingering ack.
    send_cmd(2'd0, 1'b1, 1'b0);
    host_ack(RqRst, AkRst, -1, 2, 3);
    wait_idle();
    gpio_in[AkRst] = 1'b1;
    send_cmd(2'd0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("rtz_busy", 32'(busy), 32'd1);
      chk("rtz_no_req", 32'(gpio_out[RqRst]), 32'd0);
      tick();
    end
    gpio_in[AkRst] = 1'b0;
    host_ack(RqRst, AkRst, -1, 1, 1);
    wait_idle();

    // Release with ack held high; stays sticky through a wakeup, cleared by host reset.
    gpio_in[AkRel] = 1'b1;
    send_cmd(2'd2, 1'b1, 1'b0);
    ack_given = 1'b1;
    wait_idle();
    chk("rel_sticky", 32'(gpio_out[RqRel]), 32'd1);
    send_cmd(2'd1, 1'b1, 1'b0);
    host_ack(RqWake, AkWake, AkRst, 1, 2);
    chk("rel_through_wake", 32'(gpio_out[RqRel]), 32'd1);
    wait_idle();
    send_cmd(2'd0, 1'b1, 1'b0);
    chk("rel_cleared", 32'(gpio_out[RqRel]), 32'd0);
    host_ack(RqRst, AkRst, -1, 0, 1);
    wait_idle();
    gpio_in[AkRel] = 1'b0;

    // Reset mid-handshake: request drops with no pulse.
    send_cmd(2'd0, 1'b0, 1'b0);
    chk("abort_req_up", 32'(gpio_out[RqRst]), 32'd1);
    rst = 1'b1;
    tick();
    chk("abort_gpio", gpio_out, 32'h0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_err", 32'(err_timeout), 32'd0);
    rst   = 1'b0;
    rel_m = 1'b0;
    repeat (3) tick();

    // Reserved command with the release request set: error pulse, gpio_out untouched.
    gpio_in[AkRel] = 1'b1;
    send_cmd(2'd2, 1'b1, 1'b0);
    ack_given = 1'b1;
    wait_idle();
    gpio_in[AkRel] = 1'b0;
    g = gpio_out;
    send_cmd(2'd3, 1'b1, 1'b1);
    chk("rsv_err_pulse", 32'(err_timeout), 32'd1);
    chk("rsv_gpio_same", gpio_out, g);
    tick();
    chk("rsv_err_once", 32'(err_timeout), 32'd0);
    wait_idle();

`ifdef HOST_HS_TIMEOUT_EN
    // Wakeup with no ack: error 16 cycles after REQ entry.
    send_cmd(2'd1, 1'b1, 1'b1);
    repeat (ToCycles - 1) tick();
    chk("to_not_early", 32'(err_timeout), 32'd0);
    tick();
    chk("to_err", 32'(err_timeout), 32'd1);
    chk("to_req_dropped", 32'(gpio_out[RqWake]), 32'd0);
    wait_idle();
    // Ack on the last REQ cycle beats the timeout.
    send_cmd(2'd1, 1'b1, 1'b0);
    repeat (ToCycles - 1) tick();
    gpio_in[AkWake] = 1'b1;
    ack_given = 1'b1;
    tick();
    chk("to_ack_wins", 32'(err_timeout), 32'd0);
    gpio_in[AkWake] = 1'b0;
    wait_idle();
`endif

    // Random commands, delays, foreign acks and noise on unused GPIO inputs.
    for (int it = 0; it < 30; it++) begin
      gpio_in = GpioN'($urandom) & ~32'hA2;
      t = int'($urandom_range(0, 3));
      d = int'($urandom_range(0, 4));
      h = int'($urandom_range(1, 3));
      rq = (t == 0) ? RqRst : (t == 1) ? RqWake : RqRel;
      ak = (t == 0) ? AkRst : (t == 1) ? AkWake : AkRel;
      wrong = ($urandom_range(0, 1) == 0) ? -1 : (t == 0) ? AkWake : (t == 1) ? AkRel : AkRst;
      if (t == 3) begin
        send_cmd(2'd3, 1'b1, 1'b1);
      end else begin
        send_cmd(2'(t), 1'b1, 1'b0);
        host_ack(rq, ak, wrong, d, h);
      end
      wait_idle();
      chk("rand_rel_bit", 32'(gpio_out[RqRel]), 32'(rel_m));
    end

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
